// File: rtl/cell_pkg.sv
// Shared helpers for the cell datapath elements.
//   count_width : bits needed to hold an occupancy of 0..depth
//   round_const : round-half-up bias added before an arithmetic right shift
//   sat_narrow  : clamps a signed value to out_msb+1 bits and reports clipping
package cell_pkg;

  localparam int unsigned NARROW_W = 64;

  // Narrowing result; value is sign-extended to NARROW_W.
  typedef struct packed {
    logic [NARROW_W-1:0] value;
    logic                clip;
  } narrow_t;

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [NARROW_W-1:0] round_const(input int unsigned shift);
    logic [NARROW_W-1:0] r;
    r = '0;
    if (shift != 0) r = NARROW_W'(1) << (shift - 1);
    return r;
  endfunction

  function automatic narrow_t sat_narrow(input logic signed [NARROW_W-1:0] x,
                                         input int unsigned out_msb);
    logic signed [NARROW_W-1:0] hi;
    logic signed [NARROW_W-1:0] lo;
    narrow_t r;
    hi = (NARROW_W'(1) << out_msb) - NARROW_W'(1);
    lo = ~hi;
    r.value = x;
    r.clip  = 1'b0;
    if (x > hi) begin
      r.value = hi;
      r.clip  = 1'b1;
    end else if (x < lo) begin
      r.value = lo;
      r.clip  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/outport_fifo.sv
// First-word-fall-through FIFO with registered head, valid and level.
//   clk, rst_n : clock, synchronous active-low reset
//   push/wr_data : write one word (caller guarantees room or a same-cycle pop)
//   pop          : consume the head (only while valid)
//   rd_data      : head word, 0 when empty
//   valid        : FIFO not empty
//   level        : occupancy 0..DEPTH
module outport_fifo
  import cell_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          valid,
  output logic [count_width(DEPTH)-1:0] level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_nxt_c;
  logic [AW-1:0]    rd_nxt_c;
  logic [LVL_W-1:0] level_nxt_c;
  logic [WIDTH-1:0] head_nxt_c;

  // Next pointers, level and head word. The head bypasses the array when
  // the word being written becomes the only entry.
  always_comb begin
    rd_nxt_c    = rd_ptr + AW'(pop);
    wr_nxt_c    = wr_ptr + AW'(push);
    level_nxt_c = level + LVL_W'(push) - LVL_W'(pop);
    head_nxt_c  = mem[rd_nxt_c];
    if (level_nxt_c == '0)
      head_nxt_c = '0;
    else if (push && (level == LVL_W'(pop)))
      head_nxt_c = wr_data;
  end

  // Storage array; contents are don't-care while the level says empty.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= wr_data;
  end

  // Control and registered head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      valid   <= 1'b0;
      rd_data <= '0;
    end else begin
      wr_ptr  <= wr_nxt_c;
      rd_ptr  <= rd_nxt_c;
      level   <= level_nxt_c;
      valid   <= (level_nxt_c != '0);
      rd_data <= head_nxt_c;
    end
  end

endmodule

// File: rtl/outport.sv
// Egress stage: rescales internal samples (shift, round-half-up, saturate
// or wrap), buffers them and hands them out over valid/ready.
//   clk, rst_n        : clock, synchronous active-low reset
//   internal_data(_en): signed internal sample and its one-cycle qualifier
//   out_data/out_valid/out_ready : external handshake, head of the FIFO
//   level             : FIFO occupancy
//   overflow          : sticky, a word was dropped on a full FIFO
//   sat               : sticky, a clipped word was buffered
//   clear             : clears overflow and sat (a same-edge event wins)
// Build option: define OUTPORT_SATURATE_EN to clamp instead of wrapping;
// without it sat is tied low and the clip logic is absent.
module outport
  import cell_pkg::*;
#(
  parameter int unsigned MSB     = 31,
  parameter int unsigned OUT_MSB = 15,
  parameter int unsigned SHIFT   = 8,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [MSB:0]                  internal_data,
  input  logic                          internal_data_en,
  output logic [OUT_MSB:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [count_width(DEPTH)-1:0] level,
  output logic                          overflow,
  output logic                          sat,
  input  logic                          clear
);

  localparam int unsigned EXT_W = MSB + 2;
  localparam int unsigned OUT_W = OUT_MSB + 1;
  localparam int unsigned LVL_W = count_width(DEPTH);

  logic signed [EXT_W-1:0] ext_c;
  logic signed [EXT_W-1:0] sum_c;
  logic        [OUT_W-1:0] y_c;
  logic                    clip_c;

  logic             stage_valid;
  logic [OUT_W-1:0] stage_data;
  logic             stage_clip;

  logic pop_c;
  logic push_c;
  logic drop_c;

  // Sign-extend one bit so the rounding bias can never overflow.
  always_comb begin
    ext_c = {internal_data[MSB], internal_data};
    sum_c = ext_c + signed'(EXT_W'(round_const(SHIFT)));
  end

`ifdef OUTPORT_SATURATE_EN
  logic signed [EXT_W-1:0] t_c;
  narrow_t                 narrow_c;
  logic                    unused_narrow_c;

  always_comb begin
    t_c             = sum_c >>> SHIFT;
    narrow_c        = sat_narrow({{(NARROW_W-EXT_W){t_c[EXT_W-1]}}, t_c}, OUT_MSB);
    y_c             = narrow_c.value[OUT_W-1:0];
    clip_c          = narrow_c.clip;
    unused_narrow_c = ^narrow_c.value[NARROW_W-1:OUT_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                stage_clip <= 1'b0;
    else if (internal_data_en) stage_clip <= clip_c;
  end
`else
  // Two's-complement wrap: keep the low bits of the shifted value.
  always_comb begin
    y_c    = OUT_W'(sum_c >>> SHIFT);
    clip_c = 1'b0;
  end

  assign stage_clip = 1'b0;
`endif

  // Convert stage register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_data  <= '0;
    end else begin
      stage_valid <= internal_data_en;
      if (internal_data_en) stage_data <= y_c;
    end
  end

  // A full FIFO still accepts a word when the head leaves on the same edge.
  always_comb begin
    pop_c  = out_valid && out_ready;
    push_c = stage_valid && ((level != LVL_W'(DEPTH)) || pop_c);
    drop_c = stage_valid && !push_c;
  end

  outport_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_c),
    .wr_data (stage_data),
    .pop     (pop_c),
    .rd_data (out_data),
    .valid   (out_valid),
    .level   (level)
  );

  // Sticky flags; an event on the same edge as clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      sat      <= 1'b0;
    end else begin
      if (drop_c)     overflow <= 1'b1;
      else if (clear) overflow <= 1'b0;
`ifdef OUTPORT_SATURATE_EN
      if (push_c && stage_clip) sat <= 1'b1;
      else if (clear)           sat <= 1'b0;
`else
      sat <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_outport.sv
module tb_outport;

  localparam int MSB     = 31;
  localparam int OUT_MSB = 15;
  localparam int SHIFT   = 8;
  localparam int DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] internal_data;
  logic        internal_data_en;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  level;
  logic        overflow;
  logic        sat;
  logic        clear;

  always #5 clk = ~clk;

  outport #(
    .MSB     (MSB),
    .OUT_MSB (OUT_MSB),
    .SHIFT   (SHIFT),
    .DEPTH   (DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .internal_data    (internal_data),
    .internal_data_en (internal_data_en),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .level            (level),
    .overflow         (overflow),
    .sat              (sat),
    .clear            (clear)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state: pending converted word, output queue, flags.
  bit          m_sv;
  logic [15:0] m_sy;
  bit          m_sc;
  logic [15:0] q[$];
  bit          m_ov;
  bit          m_sat;

  typedef struct {
    string       name;
    logic [31:0] din;
    logic [15:0] dout;
    bit          dsat;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %h, required %h", name, cyc, act, exp);
    end
  endtask

  // Scale by 2^-SHIFT with round-half-up, i.e. floor(x/2^S + 1/2), then
  // either clamp or keep the low 16 bits.
  function automatic void conv(input logic [31:0] x, output logic [15:0] y, output bit clip);
    longint v, t, p;
    v = longint'($signed(x));
    p = longint'(1) << SHIFT;
    v = v + p / 2;
    t = (v >= 0) ? v / p : -((-v + p - 1) / p);
    clip = 1'b0;
`ifdef OUTPORT_SATURATE_EN
    if (t > 32767) begin
      t = 32767;
      clip = 1'b1;
    end else if (t < -32768) begin
      t = -32768;
      clip = 1'b1;
    end
`endif
    y = t[15:0];
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then
  // compare every output against it.
  task automatic step();
    bit pop, push, drop;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_sv = 0; m_sc = 0; m_sy = '0; m_ov = 0; m_sat = 0;
      q.delete();
    end else begin
      pop  = (q.size() != 0) && out_ready;
      push = m_sv && ((q.size() < DEPTH) || pop);
      drop = m_sv && !push;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(m_sy);
      if (drop) m_ov = 1;
      else if (clear) m_ov = 0;
      if (push && m_sc) m_sat = 1;
      else if (clear) m_sat = 0;
      m_sv = internal_data_en;
      if (internal_data_en) conv(internal_data, m_sy, m_sc);
    end
    #1;
    chk("model/out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("model/out_data",  32'(out_data),  (q.size() != 0) ? 32'(q[0]) : 32'h0);
    chk("model/level",     32'(level),     32'(q.size()));
    chk("model/overflow",  32'(overflow),  32'(m_ov));
    chk("model/sat",       32'(sat),       32'(m_sat));
  endtask

  task automatic push_words(input int first, input int count);
    for (int k = 0; k < count; k++) begin
      internal_data    = 32'((first + k) << 8);
      internal_data_en = 1'b1;
      step();
    end
    internal_data_en = 1'b0;
    step();
  endtask

  initial begin
    bit s1;
    s1 = 0;
`ifdef OUTPORT_SATURATE_EN
    s1 = 1;
`endif
    vt[0] = '{"round_pos",  32'h0000_1280, 16'h0013, 1'b0};
    vt[1] = '{"round_neg",  32'hFFFF_ED80, 16'hFFEE, 1'b0};
    vt[2] = '{"neg_to_0",   32'hFFFF_FF80, 16'h0000, 1'b0};
    vt[3] = '{"half_up",    32'h0000_0080, 16'h0001, 1'b0};
    vt[4] = '{"below_half", 32'h0000_007F, 16'h0000, 1'b0};
    vt[5] = '{"neg_tiny",   32'hFFFF_FF7F, 16'hFFFF, 1'b0};
    vt[6] = '{"big_pos",    32'h0100_0000, s1 ? 16'h7FFF : 16'h0000, s1};
    vt[7] = '{"most_neg",   32'h8000_0000, s1 ? 16'h8000 : 16'h0000, s1};
    vt[8] = '{"most_pos",   32'h7FFF_FFFF, s1 ? 16'h7FFF : 16'h0000, s1};

    rst_n = 1'b0; internal_data = '0; internal_data_en = 1'b0;
    out_ready = 1'b0; clear = 1'b0;
    step(); step();
    chk("reset/out_valid", 32'(out_valid), 32'h0);
    chk("reset/level",     32'(level),     32'h0);
    chk("reset/out_data",  32'(out_data),  32'h0);
    chk("reset/overflow",  32'(overflow),  32'h0);
    chk("reset/sat",       32'(sat),       32'h0);
    rst_n = 1'b1;
    step();

    // Conversion vectors: word out after two edges, then drained and flags cleared.
    out_ready = 1'b1;
    foreach (vt[i]) begin
      internal_data    = vt[i].din;
      internal_data_en = 1'b1;
      step();
      internal_data_en = 1'b0;
      step();
      chk({vt[i].name, "/valid"}, 32'(out_valid), 32'h1);
      chk({vt[i].name, "/data"},  32'(out_data),  32'(vt[i].dout));
      chk({vt[i].name, "/sat"},   32'(sat),       32'(vt[i].dsat));
      clear = 1'b1;
      step();
      clear = 1'b0;
    end

    // Overflow with no pop: fifth word dropped.
    out_ready = 1'b0;
    push_words(1, 5);
    chk("ovf/level",    32'(level),    32'h4);
    chk("ovf/overflow", 32'(overflow), 32'h1);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("ovf/drain_valid", 32'(out_valid), 32'h1);
      chk("ovf/drain_data",  32'(out_data),  32'(k));
      step();
    end
    chk("ovf/empty", 32'(out_valid), 32'h0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("ovf/cleared", 32'(overflow), 32'h0);

    // Full FIFO with simultaneous push and pop.
    out_ready = 1'b0;
    push_words(1, 4);
    chk("full/level", 32'(level), 32'h4);
    internal_data = 32'h500; internal_data_en = 1'b1;
    step();
    internal_data_en = 1'b0; out_ready = 1'b1;
    step();
    chk("full/level_hold", 32'(level),    32'h4);
    chk("full/no_ovf",     32'(overflow), 32'h0);
    for (int k = 2; k <= 5; k++) begin
      chk("full/order", 32'(out_data), 32'(k));
      step();
    end
    chk("full/empty", 32'(out_valid), 32'h0);

    // Reset mid-operation with a word in flight.
    out_ready = 1'b0;
    push_words(1, 3);
    chk("rst/level3", 32'(level), 32'h3);
    internal_data = 32'h600; internal_data_en = 1'b1; rst_n = 1'b0;
    step();
    rst_n = 1'b1; internal_data_en = 1'b0;
    chk("rst/valid", 32'(out_valid), 32'h0);
    chk("rst/level", 32'(level),     32'h0);
    chk("rst/flags", {30'h0, overflow, sat}, 32'h0);
    step();
    chk("rst/no_stale", 32'(out_valid), 32'h0);
    internal_data = 32'h700; internal_data_en = 1'b1;
    step();
    internal_data_en = 1'b0;
    step();
    chk("rst/first_valid", 32'(out_valid), 32'h1);
    chk("rst/first_data",  32'(out_data),  32'h7);
    out_ready = 1'b1;
    step();

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
        0:       internal_data = r;
        1:       internal_data = {{12{r[19]}}, r[19:0]};
        default: internal_data = {{8{r[23]}}, r[23:0]};
      endcase
      internal_data_en = ($urandom_range(0, 9) < 7);
      out_ready        = ($urandom_range(0, 9) < 6);
      clear            = ($urandom_range(0, 19) == 0);
      rst_n            = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
